// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SDRAM word bridge.
package sdram_bridge_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned CNT_W  = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_LO   = 3'd1,
      WR_HI   = 3'd2,
      RD_LO   = 3'd3,
      RD_HI   = 3'd4,
      RD_WAIT = 3'd5
   } state_t;

   localparam logic       HALF_LO   = 1'b0;
   localparam logic       HALF_HI   = 1'b1;
   localparam logic [1:0] BE_NONE_N = 2'b11;
   localparam logic [1:0] BE_ALL_N  = 2'b00;

endpackage

// File: rtl/sdram_word_bridge.sv
// Splits 32-bit CPU word requests into two 16-bit Avalon-MM transfers
// (low half first) and reassembles read halves into one 32-bit response.
module sdram_word_bridge
   import sdram_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned SDR_ADDR_W = 25,
   parameter bit          SKIP_EMPTY = 1'b1
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  cpu_req_valid,
   output logic                  cpu_req_ready,
   input  logic                  cpu_req_we,
   input  logic [ADDR_W-1:0]     cpu_req_addr,
   input  logic [DATA_W-1:0]     cpu_req_wdata,
   input  logic [BE_W-1:0]       cpu_req_be,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_rvalid,
   output logic [SDR_ADDR_W-1:0] av_address,
   output logic [1:0]            av_byteenable_n,
   output logic                  av_chipselect,
   output logic [HALF_W-1:0]     av_writedata,
   output logic                  av_read_n,
   output logic                  av_write_n,
   input  logic [HALF_W-1:0]     av_readdata,
   input  logic                  av_readdatavalid,
   input  logic                  av_waitrequest
);

   state_t                  state, state_d;
   logic [ADDR_W-1:0]       addr_q;
   logic [DATA_W-1:0]       wdata_q;
   logic [BE_W-1:0]         be_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [HALF_W-1:0]       lo_q, lo_d;
   logic [DATA_W-1:0]       rdata_d;
   logic                    rvalid_d, ready_d;
   logic [SDR_ADDR_W-1:0]   av_address_d;
   logic [1:0]              av_byteenable_n_d;
   logic                    av_chipselect_d;
   logic [HALF_W-1:0]       av_writedata_d;
   logic                    av_read_n_d, av_write_n_d;

   logic                    accept, cmd_done, in_read;
   logic                    load, load_half, load_rd, clear;
   logic [1:0]              half_be;
   logic [ADDR_W-1:0]       src_addr;
   logic [DATA_W-1:0]       src_wdata;
   logic [BE_W-1:0]         src_be;

   // Handshake decode; request fields come straight from the port in the accepting cycle.
   assign accept    = cpu_req_valid & cpu_req_ready;
   assign cmd_done  = av_chipselect & ~av_waitrequest;
   assign in_read   = state inside {RD_LO, RD_HI, RD_WAIT};
   assign src_addr  = (state == IDLE) ? cpu_req_addr  : addr_q;
   assign src_wdata = (state == IDLE) ? cpu_req_wdata : wdata_q;
   assign src_be    = (state == IDLE) ? cpu_req_be    : be_q;

   // Next state, next Avalon command and read-return assembly.
   always_comb begin
      state_d           = state;
      load              = 1'b0;
      load_half         = HALF_LO;
      load_rd           = 1'b0;
      clear             = 1'b0;
      half_be           = 2'b00;
      cnt_d             = cnt_q;
      lo_d              = lo_q;
      rdata_d           = cpu_rdata;
      rvalid_d          = 1'b0;
      av_address_d      = av_address;
      av_byteenable_n_d = av_byteenable_n;
      av_chipselect_d   = av_chipselect;
      av_writedata_d    = av_writedata;
      av_read_n_d       = av_read_n;
      av_write_n_d      = av_write_n;

      case (state)
         IDLE: begin
            if (accept) begin
               if (!cpu_req_we) begin
                  state_d = RD_LO;
                  load    = 1'b1;
                  load_rd = 1'b1;
               end else if (SKIP_EMPTY && (cpu_req_be == 4'b0000)) begin
                  state_d = IDLE;
               end else if (SKIP_EMPTY && (cpu_req_be[1:0] == 2'b00)) begin
                  state_d   = WR_HI;
                  load      = 1'b1;
                  load_half = HALF_HI;
               end else begin
                  state_d = WR_LO;
                  load    = 1'b1;
               end
            end
         end
         WR_LO: begin
            if (cmd_done) begin
               if (SKIP_EMPTY && (be_q[3:2] == 2'b00)) begin
                  state_d = IDLE;
                  clear   = 1'b1;
               end else begin
                  state_d   = WR_HI;
                  load      = 1'b1;
                  load_half = HALF_HI;
               end
            end
         end
         WR_HI: begin
            if (cmd_done) begin
               state_d = IDLE;
               clear   = 1'b1;
            end
         end
         RD_LO: begin
            if (cmd_done) begin
               state_d   = RD_HI;
               load      = 1'b1;
               load_half = HALF_HI;
               load_rd   = 1'b1;
            end
         end
         RD_HI: begin
            if (cmd_done) begin
               clear = 1'b1;
               if ((cnt_q == 2'd2) || (av_readdatavalid && (cnt_q == 2'd1)))
                  state_d = IDLE;
               else
                  state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (av_readdatavalid && (cnt_q == 2'd1))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Halves may return while the high command is still stalled.
      if (in_read && av_readdatavalid) begin
         if (cnt_q == 2'd0) begin
            lo_d  = av_readdata;
            cnt_d = 2'd1;
         end else if (cnt_q == 2'd1) begin
            rdata_d  = {av_readdata, lo_q};
            rvalid_d = 1'b1;
            cnt_d    = 2'd2;
         end
      end
      if (state_d == IDLE)
         cnt_d = '0;

      // Present a new command, or drop the strobes once the last one is taken.
      if (load) begin
         half_be           = (load_half == HALF_HI) ? src_be[3:2] : src_be[1:0];
         av_address_d      = SDR_ADDR_W'({src_addr, load_half});
         av_byteenable_n_d = load_rd ? BE_ALL_N : ~half_be;
         av_chipselect_d   = 1'b1;
         av_read_n_d       = ~load_rd;
         av_write_n_d      = load_rd;
         if (!load_rd)
            av_writedata_d = (load_half == HALF_HI) ? src_wdata[31:16] : src_wdata[15:0];
      end else if (clear) begin
         av_byteenable_n_d = BE_NONE_N;
         av_chipselect_d   = 1'b0;
         av_read_n_d       = 1'b1;
         av_write_n_d      = 1'b1;
      end

      ready_d = (state_d == IDLE);
   end

   // State, request capture and all registered outputs.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state           <= IDLE;
         addr_q          <= '0;
         wdata_q         <= '0;
         be_q            <= '0;
         cnt_q           <= '0;
         lo_q            <= '0;
         cpu_rdata       <= '0;
         cpu_rvalid      <= 1'b0;
         cpu_req_ready   <= 1'b1;
         av_address      <= '0;
         av_byteenable_n <= BE_NONE_N;
         av_chipselect   <= 1'b0;
         av_writedata    <= '0;
         av_read_n       <= 1'b1;
         av_write_n      <= 1'b1;
      end else begin
         state           <= state_d;
         if (accept) begin
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_wdata;
            be_q    <= cpu_req_be;
         end
         cnt_q           <= cnt_d;
         lo_q            <= lo_d;
         cpu_rdata       <= rdata_d;
         cpu_rvalid      <= rvalid_d;
         cpu_req_ready   <= ready_d;
         av_address      <= av_address_d;
         av_byteenable_n <= av_byteenable_n_d;
         av_chipselect   <= av_chipselect_d;
         av_writedata    <= av_writedata_d;
         av_read_n       <= av_read_n_d;
         av_write_n      <= av_write_n_d;
      end
   end

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Directed bench for sdram_word_bridge with a byte-enabled SDRAM slave model.
module tb_sdram_word_bridge;

   localparam int unsigned ADDR_W     = 24;
   localparam int unsigned SDR_ADDR_W = 25;

   logic                  clk   = 1'b0;
   logic                  rst_n = 1'b1;
   logic                  cpu_req_valid = 1'b0;
   logic                  cpu_req_ready;
   logic                  cpu_req_we = 1'b0;
   logic [ADDR_W-1:0]     cpu_req_addr = '0;
   logic [31:0]           cpu_req_wdata = '0;
   logic [3:0]            cpu_req_be = '0;
   logic [31:0]           cpu_rdata;
   logic                  cpu_rvalid;
   logic [SDR_ADDR_W-1:0] av_address;
   logic [1:0]            av_byteenable_n;
   logic                  av_chipselect;
   logic [15:0]           av_writedata;
   logic                  av_read_n, av_write_n;
   logic [15:0]           av_readdata;
   logic                  av_readdatavalid;
   logic                  av_waitrequest = 1'b0;

   always #5 clk = ~clk;

   sdram_word_bridge #(.ADDR_W(ADDR_W), .SDR_ADDR_W(SDR_ADDR_W), .SKIP_EMPTY(1'b1)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
      .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .av_address(av_address), .av_byteenable_n(av_byteenable_n),
      .av_chipselect(av_chipselect), .av_writedata(av_writedata),
      .av_read_n(av_read_n), .av_write_n(av_write_n),
      .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
      .av_waitrequest(av_waitrequest)
   );

   // ---------------- slave model ----------------
   typedef struct {
      logic [24:0] a;
      logic [1:0]  ben;
      logic [15:0] d;
      logic        rd;
      logic        wr;
      int          c;
   } cmd_t;

   logic [15:0] mem [logic [24:0]];
   cmd_t        log_q[$];
   logic [7:0]  pv = '0;
   logic [15:0] pd [8];
   logic [15:0] wr_word;
   int          lat = 2;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          rv_cnt = 0;
   logic [31:0] rv_data = '0;
   int          bad_cyc = 0;
   logic        inj_v = 1'b0;
   logic [15:0] inj_d = '0;

   function automatic logic [15:0] rd_mem(input logic [24:0] a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   assign av_readdatavalid = pv[lat-1] | inj_v;
   assign av_readdata      = inj_v ? inj_d : pd[lat-1];

   // Accept commands, return read data after `lat` cycles, apply byte-enabled writes.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      pv  <= {pv[6:0], av_chipselect && !av_read_n && !av_waitrequest};
      for (int i = 7; i > 0; i--) pd[i] <= pd[i-1];
      pd[0] <= rd_mem(av_address);
      if (av_chipselect && !av_waitrequest) begin
         log_q.push_back('{av_address, av_byteenable_n, av_writedata, !av_read_n, !av_write_n, cyc});
         if (!av_write_n) begin
            wr_word = rd_mem(av_address);
            if (!av_byteenable_n[0]) wr_word[7:0]  = av_writedata[7:0];
            if (!av_byteenable_n[1]) wr_word[15:8] = av_writedata[15:8];
            mem[av_address] = wr_word;
         end
      end
      if (cpu_req_valid && cpu_req_ready) acc_cnt++;
   end

   // Response capture and bus-protocol sanity on every cycle.
   always @(negedge clk) begin
      if (cpu_rvalid) begin
         rv_cnt++;
         rv_data = cpu_rdata;
      end
      if ((!av_read_n && !av_write_n) ||
          (av_chipselect && av_read_n && av_write_n) ||
          (!av_chipselect && (!av_read_n || !av_write_n)))
         bad_cyc++;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic        we;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          ncmd;
      logic [24:0] a0;
      logic [1:0]  ben0;
      logic [15:0] d0;
      logic [24:0] a1;
      logic [1:0]  ben1;
      logic [15:0] d1;
      int          roff;
      logic [31:0] rdata;
   } vec_t;

   vec_t vt[11];

   // One request with no stalls; checks commands, timing and response.
   task automatic run_txn(input int idx, input vec_t v);
      int t0, k;
      log_q.delete();
      rv_cnt = 0;
      @(posedge clk); #1;
      cpu_req_valid = 1'b1;
      cpu_req_we    = v.we;
      cpu_req_addr  = v.addr;
      cpu_req_wdata = v.wdata;
      cpu_req_be    = v.be;
      t0 = cyc;
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      k = 1;
      @(negedge clk);
      while (!cpu_req_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_cycle", idx), 64'(k), 64'(v.roff));
      chk($sformatf("v%0d_ncmd", idx), 64'(log_q.size()), 64'(v.ncmd));
      for (int i = 0; i < v.ncmd && i < log_q.size(); i++) begin
         chk($sformatf("v%0d_c%0d_addr", idx, i), 64'(log_q[i].a), 64'((i == 0) ? v.a0 : v.a1));
         chk($sformatf("v%0d_c%0d_ben", idx, i), 64'(log_q[i].ben), 64'((i == 0) ? v.ben0 : v.ben1));
         chk($sformatf("v%0d_c%0d_kind", idx, i), 64'({log_q[i].rd, log_q[i].wr}),
             64'(v.we ? 2'b01 : 2'b10));
         chk($sformatf("v%0d_c%0d_cycle", idx, i), 64'(log_q[i].c), 64'(t0 + 1 + i));
         if (v.we)
            chk($sformatf("v%0d_c%0d_data", idx, i), 64'(log_q[i].d), 64'((i == 0) ? v.d0 : v.d1));
      end
      chk($sformatf("v%0d_rvalid_count", idx), 64'(rv_cnt), 64'(v.we ? 0 : 1));
      if (!v.we)
         chk($sformatf("v%0d_rdata", idx), 64'(rv_data), 64'(v.rdata));
   endtask

   initial begin
      int  ta, tb_acc;
      logic r;

      vt[0]  = '{1'b1, 24'h000010, 32'h12345678, 4'hF, 2, 25'h20, 2'b00, 16'h5678, 25'h21, 2'b00, 16'h1234, 3, 32'h0};
      vt[1]  = '{1'b0, 24'h000010, 32'h0, 4'hF, 2, 25'h20, 2'b00, 16'h0, 25'h21, 2'b00, 16'h0, 5, 32'h12345678};
      vt[2]  = '{1'b1, 24'h000010, 32'hAABBCCDD, 4'b1100, 1, 25'h21, 2'b00, 16'hAABB, 25'h0, 2'b11, 16'h0, 2, 32'h0};
      vt[3]  = '{1'b0, 24'h000010, 32'h0, 4'hF, 2, 25'h20, 2'b00, 16'h0, 25'h21, 2'b00, 16'h0, 5, 32'hAABB5678};
      vt[4]  = '{1'b1, 24'h000010, 32'h00009999, 4'b0000, 0, 25'h0, 2'b11, 16'h0, 25'h0, 2'b11, 16'h0, 1, 32'h0};
      vt[5]  = '{1'b1, 24'h000010, 32'hFFFF1122, 4'b0011, 1, 25'h20, 2'b00, 16'h1122, 25'h0, 2'b11, 16'h0, 2, 32'h0};
      vt[6]  = '{1'b1, 24'h000ABC, 32'h77665544, 4'b0110, 2, 25'h1578, 2'b01, 16'h5544, 25'h1579, 2'b10, 16'h7766, 3, 32'h0};
      vt[7]  = '{1'b0, 24'h000010, 32'h0, 4'hF, 2, 25'h20, 2'b00, 16'h0, 25'h21, 2'b00, 16'h0, 5, 32'hAABB1122};
      vt[8]  = '{1'b0, 24'h000ABC, 32'h0, 4'hF, 2, 25'h1578, 2'b00, 16'h0, 25'h1579, 2'b00, 16'h0, 5, 32'h00665500};
      vt[9]  = '{1'b1, 24'hFFFFFF, 32'hCAFEF00D, 4'hF, 2, 25'h1FFFFFE, 2'b00, 16'hF00D, 25'h1FFFFFF, 2'b00, 16'hCAFE, 3, 32'h0};
      vt[10] = '{1'b0, 24'hFFFFFF, 32'h0, 4'hF, 2, 25'h1FFFFFE, 2'b00, 16'h0, 25'h1FFFFFF, 2'b00, 16'h0, 5, 32'hCAFEF00D};

      // Reset values.
      #1 rst_n = 1'b0;
      #11;
      chk("reset_outputs",
          64'({av_chipselect, av_read_n, av_write_n, av_byteenable_n, av_address, av_writedata,
               cpu_req_ready, cpu_rvalid, cpu_rdata}),
          64'({1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b1, 1'b0, 32'h0}));
      @(posedge clk); #1 rst_n = 1'b1;

      // Table-driven transactions.
      for (int i = 0; i < 11; i++) run_txn(i, vt[i]);

      // Low half stalled by waitrequest for three cycles.
      log_q.delete();
      @(posedge clk); #1;
      av_waitrequest = 1'b1;
      cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 24'h000020;
      cpu_req_wdata = 32'hBEEF0123; cpu_req_be = 4'hF;
      @(posedge clk); #1 cpu_req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("stall_hold_%0d", i),
             64'({av_chipselect, av_write_n, av_read_n, av_address, av_byteenable_n, av_writedata}),
             64'({1'b1, 1'b0, 1'b1, 25'h40, 2'b00, 16'h0123}));
         if (i == 2) begin
            @(posedge clk); #1 av_waitrequest = 1'b0;
         end
      end
      @(negedge clk);
      chk("stall_high_half",
          64'({av_chipselect, av_write_n, av_read_n, av_address, av_byteenable_n, av_writedata, cpu_req_ready}),
          64'({1'b1, 1'b0, 1'b1, 25'h41, 2'b00, 16'hBEEF, 1'b0}));
      @(negedge clk);
      chk("stall_done", 64'({cpu_req_ready, av_chipselect}), 64'({1'b1, 1'b0}));
      chk("stall_ncmd", 64'(log_q.size()), 64'(2));

      // Reset while waiting for the high half, then a stray valid after release.
      rv_cnt = 0;
      @(posedge clk); #1;
      cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 24'h000010;
      @(posedge clk); #1 cpu_req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_outputs",
          64'({av_chipselect, av_read_n, av_write_n, av_byteenable_n, av_address, av_writedata,
               cpu_req_ready, cpu_rvalid, cpu_rdata}),
          64'({1'b1 ^ 1'b1, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b1, 1'b0, 32'h0}));
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1 inj_v = 1'b1; inj_d = 16'hBAD1;
      @(posedge clk); #1 inj_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midreset_no_rvalid", 64'(rv_cnt), 64'(0));
      chk("midreset_idle", 64'({cpu_req_ready, av_chipselect, cpu_rdata}), 64'({1'b1, 1'b0, 32'h0}));
      run_txn(20, vt[7]);

      // Back-to-back read then write with valid held high.
      log_q.delete();
      rv_cnt = 0;
      acc_cnt = 0;
      ta = -1;
      tb_acc = -1;
      @(posedge clk); #1;
      cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 24'h000ABC;
      for (int c = 0; c < 40 && tb_acc < 0; c++) begin
         @(negedge clk);
         r = cpu_req_ready;
         @(posedge clk); #1;
         if (r) begin
            if (ta < 0) begin
               ta = c;
               cpu_req_we = 1'b1; cpu_req_addr = 24'h000030;
               cpu_req_wdata = 32'h0BADF00D; cpu_req_be = 4'hF;
            end else begin
               tb_acc = c;
               cpu_req_valid = 1'b0;
            end
         end
      end
      cpu_req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("b2b_accept_gap", 64'(tb_acc - ta), 64'(5));
      chk("b2b_accept_count", 64'(acc_cnt), 64'(2));
      chk("b2b_rdata", 64'({rv_cnt[3:0], rv_data}), 64'({4'd1, 32'h00665500}));
      chk("b2b_ncmd", 64'(log_q.size()), 64'(4));
      if (log_q.size() == 4) begin
         chk("b2b_order", 64'({log_q[0].rd, log_q[1].rd, log_q[2].wr, log_q[3].wr}), 64'(4'b1111));
         chk("b2b_no_overlap", 64'(log_q[2].c > log_q[1].c + 2), 64'(1));
      end

      chk("bus_protocol_cycles", 64'(bad_cyc), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
